// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MC_WAIT   = 2'd1,
    WFI_SLEEP = 2'd2
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the load in EX and the
// instruction in ID, accounting for integer vs FP register files.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_fprs1,
  input  logic             id_fprs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_fp_regwrite,
  output logic             lu
);

  // x0 is hardwired zero and never forwards a load result; f0 is a real register.
  function automatic logic src_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic             rd_fp,
                                     input logic             rs_fp);
    return (rd == rs) && (rd_fp == rs_fp) && (rd_fp || (rd != '0));
  endfunction

  assign lu = ex_memread &&
              (src_match(ex_rd, id_rs, ex_fp_regwrite, id_fprs1) ||
               src_match(ex_rd, id_rt, ex_fp_regwrite, id_fprs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: load-use bubbles, multi-cycle EX stalls, WFI
// sleep and machine interrupt entry/exit, with a single fixed priority.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             Controller_fprs1,
  input  logic             Controller_fprs2,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             ID_EX_memread_1bit,
  input  logic             ID_EX_fp_regwrite,
  input  logic             im_stall,
  input  logic             dm_stall,
  input  logic             br_redirect,
  input  logic             mc_start,
  input  logic [CNT_W-1:0] mc_cycles,
  input  logic             wfi_ex,
  input  logic             mret_ex,
  input  logic             irq_ext,
  input  logic             irq_timer,
  input  logic             mie_global,
  output logic             stall_CPU,
  output logic             stall_hazard,
  output logic             jump_taken,
  output logic             MEIP_en,
  output logic             MTIP_en,
  output logic             MEIP_end,
  output logic             WFI_pc_en
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_done_q, mc_done_d;
  logic             in_trap_q, in_trap_d;

  logic lu;
  logic acc, stall_cpu, take_ok, take_ext, take_tmr, mret_end, wake;

  load_use_detect u_lu (
    .id_rs          (IF_ID_rs),
    .id_rt          (IF_ID_rt),
    .id_fprs1       (Controller_fprs1),
    .id_fprs2       (Controller_fprs2),
    .ex_rd          (ID_EX_rd),
    .ex_memread     (ID_EX_memread_1bit),
    .ex_fp_regwrite (ID_EX_fp_regwrite),
    .lu             (lu)
  );

  always_comb begin
    acc       = (state_q == RUN) && mc_start && (mc_cycles != '0) && !mc_done_q;
    stall_cpu = im_stall || dm_stall || acc ||
                (state_q == MC_WAIT) || (state_q == WFI_SLEEP);
    // A take needs a clean RUN cycle: no freeze, no bubble, no redirect in flight.
    take_ok   = (state_q == RUN) && !stall_cpu && !lu && !br_redirect && !in_trap_q;
    take_ext  = take_ok && irq_ext && mie_global;
    take_tmr  = take_ok && !irq_ext && irq_timer && mie_global;
    mret_end  = mret_ex && !stall_cpu;
    wake      = (state_q == WFI_SLEEP) && (irq_ext || irq_timer);
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_done_d = stall_cpu ? mc_done_q : 1'b0;
    in_trap_d = in_trap_q;

    if (take_ext || take_tmr) in_trap_d = 1'b1;
    else if (mret_end)        in_trap_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (acc) begin
          cnt_d = mc_cycles - CNT_W'(1);
          if (cnt_d != '0) state_d   = MC_WAIT;
          else             mc_done_d = 1'b1;
        end else if (wfi_ex && !(irq_ext || irq_timer)) begin
          state_d = WFI_SLEEP;
        end
      end
      MC_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d     = '0;
          state_d   = RUN;
          mc_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WFI_SLEEP: begin
        if (wake) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mc_done_q <= 1'b0;
      in_trap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mc_done_q <= mc_done_d;
      in_trap_q <= in_trap_d;
    end
  end

  // NOTE: outputs are gated by rst_n so they are forced low while reset is held,
  // even though they are combinational from live inputs.
  assign stall_CPU    = rst_n && stall_cpu;
  assign stall_hazard = rst_n && lu && !stall_cpu;
  assign jump_taken   = rst_n && br_redirect && !stall_cpu;
  assign MEIP_en      = rst_n && take_ext;
  assign MTIP_en      = rst_n && take_tmr;
  assign MEIP_end     = rst_n && mret_end;
  assign WFI_pc_en    = rst_n && wake;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push
// hand-computed output expectations; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // Expected-output bit positions: {stall_CPU, stall_hazard, jump_taken,
  // MEIP_en, MTIP_en, MEIP_end, WFI_pc_en}
  localparam logic [6:0] X_NONE = 7'h00;
  localparam logic [6:0] X_CPU  = 7'h40;
  localparam logic [6:0] X_HZ   = 7'h20;
  localparam logic [6:0] X_JMP  = 7'h10;
  localparam logic [6:0] X_MEIP = 7'h08;
  localparam logic [6:0] X_MTIP = 7'h04;
  localparam logic [6:0] X_END  = 7'h02;
  localparam logic [6:0] X_WFI  = 7'h01;

  logic             clk, rst_n;
  logic [REG_W-1:0] IF_ID_rs, IF_ID_rt, ID_EX_rd;
  logic             Controller_fprs1, Controller_fprs2;
  logic             ID_EX_memread_1bit, ID_EX_fp_regwrite;
  logic             im_stall, dm_stall, br_redirect, mc_start;
  logic [CNT_W-1:0] mc_cycles;
  logic             wfi_ex, mret_ex, irq_ext, irq_timer, mie_global;
  logic             stall_CPU, stall_hazard, jump_taken;
  logic             MEIP_en, MTIP_en, MEIP_end, WFI_pc_en;

  logic [6:0] exp_q[$];
  string      name_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  logic [6:0] mon_exp, mon_act;
  string      mon_name;

  pipe_hazard_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .IF_ID_rs           (IF_ID_rs),
    .IF_ID_rt           (IF_ID_rt),
    .Controller_fprs1   (Controller_fprs1),
    .Controller_fprs2   (Controller_fprs2),
    .ID_EX_rd           (ID_EX_rd),
    .ID_EX_memread_1bit (ID_EX_memread_1bit),
    .ID_EX_fp_regwrite  (ID_EX_fp_regwrite),
    .im_stall           (im_stall),
    .dm_stall           (dm_stall),
    .br_redirect        (br_redirect),
    .mc_start           (mc_start),
    .mc_cycles          (mc_cycles),
    .wfi_ex             (wfi_ex),
    .mret_ex            (mret_ex),
    .irq_ext            (irq_ext),
    .irq_timer          (irq_timer),
    .mie_global         (mie_global),
    .stall_CPU          (stall_CPU),
    .stall_hazard       (stall_hazard),
    .jump_taken         (jump_taken),
    .MEIP_en            (MEIP_en),
    .MTIP_en            (MTIP_en),
    .MEIP_end           (MEIP_end),
    .WFI_pc_en          (WFI_pc_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {stall_CPU, stall_hazard, jump_taken,
                  MEIP_en, MTIP_en, MEIP_end, WFI_pc_en};
      n_vec++;
      if (mon_act !== mon_exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b (CPU HZ JMP MEIP MTIP END WFI)",
                 mon_name, mon_act, mon_exp);
      end
    end
  end

  task automatic idle();
    IF_ID_rs = '0; IF_ID_rt = '0; ID_EX_rd = '0;
    Controller_fprs1 = 1'b0; Controller_fprs2 = 1'b0;
    ID_EX_memread_1bit = 1'b0; ID_EX_fp_regwrite = 1'b0;
    im_stall = 1'b0; dm_stall = 1'b0; br_redirect = 1'b0;
    mc_start = 1'b0; mc_cycles = '0;
    wfi_ex = 1'b0; mret_ex = 1'b0;
    irq_ext = 1'b0; irq_timer = 1'b0; mie_global = 1'b0;
  endtask

  // Inputs are already applied; record the expectation for this cycle and
  // advance to just after the next rising edge.
  task automatic step(input string name, input logic [6:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd, input logic fp_wr,
                      input logic [4:0] rs, input logic fp1,
                      input logic [4:0] rt, input logic fp2);
    ID_EX_memread_1bit = 1'b1; ID_EX_rd = rd; ID_EX_fp_regwrite = fp_wr;
    IF_ID_rs = rs; Controller_fprs1 = fp1;
    IF_ID_rt = rt; Controller_fprs2 = fp2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Outputs forced low in reset even with live requests
    im_stall = 1'b1; br_redirect = 1'b1; mret_ex = 1'b1;
    step("reset_outs", X_NONE);
    idle(); rst_n = 1'b1;
    step("post_reset_idle", X_NONE);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    load(5'd5, 1'b0, 5'd5, 1'b0, 5'd1, 1'b0);
    step("lu_int_rs", X_HZ);
    idle();
    step("lu_bubble_gone", X_NONE);
    load(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("lu_x0_nomatch", X_NONE);
    load(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b0);
    step("lu_fp_f0", X_HZ);
    load(5'd5, 1'b1, 5'd5, 1'b0, 5'd7, 1'b0);
    step("lu_file_mismatch", X_NONE);
    load(5'd9, 1'b0, 5'd2, 1'b0, 5'd9, 1'b0);
    step("lu_int_rt", X_HZ);
    idle();

    // Multi-cycle op of 4 held in EX
    mc_start = 1'b1; mc_cycles = 5'd4;
    for (int i = 0; i < 4; i++) step($sformatf("mc4_stall%0d", i), X_CPU);
    step("mc4_no_reaccept", X_NONE);
    idle();
    step("mc4_left", X_NONE);

    mc_start = 1'b1; mc_cycles = 5'd1;
    step("mc1_stall", X_CPU);
    step("mc1_no_reaccept", X_NONE);
    idle();
    mc_start = 1'b1; mc_cycles = 5'd0;
    step("mc0_no_stall", X_NONE);
    idle();

    // Priority: memory stall over hazard over redirect
    dm_stall = 1'b1; br_redirect = 1'b1;
    load(5'd5, 1'b0, 5'd5, 1'b0, 5'd1, 1'b0);
    step("prio_dm_stall", X_CPU);
    dm_stall = 1'b0;
    step("prio_hz_and_jmp", X_HZ | X_JMP);
    idle();

    // WFI sleep, wake by timer with MIE off
    wfi_ex = 1'b1;
    step("wfi_enter", X_NONE);
    step("wfi_sleep0", X_CPU);
    step("wfi_sleep1", X_CPU);
    irq_timer = 1'b1;
    step("wfi_wake", X_CPU | X_WFI);
    step("wfi_pending_nop", X_NONE);
    idle();

    // Interrupt deferred by redirect, external beats timer, blocked until MRET
    irq_ext = 1'b1; irq_timer = 1'b1; mie_global = 1'b1; br_redirect = 1'b1;
    step("irq_defer_jmp", X_JMP);
    br_redirect = 1'b0;
    step("irq_meip", X_MEIP);
    step("irq_blocked0", X_NONE);
    step("irq_blocked1", X_NONE);
    irq_ext = 1'b0; irq_timer = 1'b0; mret_ex = 1'b1;
    step("mret_end", X_END);
    mret_ex = 1'b0; irq_timer = 1'b1;
    step("irq_mtip", X_MTIP);
    irq_timer = 1'b0; mret_ex = 1'b1;
    step("mret_end2", X_END);
    mret_ex = 1'b0; irq_ext = 1'b1; mie_global = 1'b0;
    step("irq_masked", X_NONE);
    idle();

    // Reset in the middle of a 6-cycle MC_WAIT aborts immediately
    mc_start = 1'b1; mc_cycles = 5'd6;
    step("mc6_accept", X_CPU);
    step("mc6_wait1", X_CPU);
    rst_n = 1'b0; mc_start = 1'b0; mc_cycles = '0;
    step("mc6_reset", X_NONE);
    rst_n = 1'b1;
    step("mc6_after_reset", X_NONE);
    mc_start = 1'b1; mc_cycles = 5'd2;
    step("mc2_stall0", X_CPU);
    step("mc2_stall1", X_CPU);
    step("mc2_done", X_NONE);
    idle();
    step("final_idle", X_NONE);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
